// File: rtl/leds.sv
// leds - driver for the eight user LEDs on the Alhambra-II board.
//
// Each LED shows a fixed on/off PATTERN bit, gated by a free-running PWM
// comparator. An optional soft-start ramp raises the effective duty from 0
// up to DUTY, one step every RAMP_STEP cycles, after reset is released.
// With the default parameters every LED is steadily lit from the first edge
// after reset.
//
// Parameters:
//   PATTERN   bit i lights LEDi (1) or holds it off (0)
//   PWM_BITS  PWM counter width; the PWM period is 2**PWM_BITS cycles
//   DUTY      on-cycles per period, 0..2**PWM_BITS (larger values saturate)
//   RAMP_STEP soft-start step interval in cycles; 0 disables the ramp
//
// Ports:
//   CLK        in   system clock, rising-edge active
//   RST        in   synchronous active-high reset
//   LED0..LED7 out  registered LED drives, active-high (1 = lit)

module leds #(
  parameter logic [7:0] PATTERN   = 8'hFF,
  parameter int         PWM_BITS  = 4,
  parameter int         DUTY      = 16,
  parameter int         RAMP_STEP = 0
) (
  input  logic CLK,
  input  logic RST,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7
);

  localparam int FULL     = 1 << PWM_BITS;
  localparam int DUTY_SAT = (DUTY > FULL) ? FULL : ((DUTY < 0) ? 0 : DUTY);
  localparam int RW       = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;

  // The duty lives at PWM_BITS+1 width so that "always on" (2**PWM_BITS) fits.
  localparam logic [PWM_BITS:0] DUTY_V    = DUTY_SAT[PWM_BITS:0];
  localparam logic [PWM_BITS:0] EFF_INIT  = (RAMP_STEP > 0) ? '0 : DUTY_V;
  localparam int                RAMP_LI   = (RAMP_STEP > 0) ? RAMP_STEP - 1 : 0;
  localparam logic [RW-1:0]     RAMP_LAST = RAMP_LI[RW-1:0];

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS:0]   eff_duty;
  logic [RW-1:0]       ramp_cnt;
  logic [7:0]          led;
  logic                pwm_on;

  assign pwm_on = ({1'b0, pwm_cnt} < eff_duty);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt  <= '0;
      ramp_cnt <= '0;
      eff_duty <= EFF_INIT;
      led      <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led     <= PATTERN & {8{pwm_on}};
      // Ramp stops counting once the target duty is reached; a step taken
      // on this edge only affects the comparison from the next cycle.
      if ((RAMP_STEP > 0) && (eff_duty < DUTY_V)) begin
        if (ramp_cnt == RAMP_LAST) begin
          ramp_cnt <= '0;
          eff_duty <= eff_duty + 1'b1;
        end else begin
          ramp_cnt <= ramp_cnt + 1'b1;
        end
      end
    end
  end

  assign LED0 = led[0];
  assign LED1 = led[1];
  assign LED2 = led[2];
  assign LED3 = led[3];
  assign LED4 = led[4];
  assign LED5 = led[5];
  assign LED6 = led[6];
  assign LED7 = led[7];

endmodule

// File: tb/tb_leds.sv
// tb_leds - several parameterisations of leds share one clock and one reset;
// each is compared every cycle with a cycle-count model of the LED rules.

module tb_leds;

  localparam int NCFG = 9;
  localparam int P_PAT  [NCFG] = '{8'hFF, 8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC3, 8'hFF, 8'h3C};
  localparam int P_BITS [NCFG] = '{4,     4,     2,     2,     2,     2,     2,     4,     3    };
  localparam int P_DUTY [NCFG] = '{16,    16,    1,     0,     4,     4,     2,     20,    5    };
  localparam int P_STEP [NCFG] = '{0,     0,     0,     0,     0,     4,     0,     0,     3    };

  logic clk = 1'b0;
  logic rst = 1'b0;
  wire [7:0] led_o [NCFG];

  int n_chk  = 0;
  int n_fail = 0;
  int n_since = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    leds #(
      .PATTERN  (8'(P_PAT[g])),
      .PWM_BITS (P_BITS[g]),
      .DUTY     (P_DUTY[g]),
      .RAMP_STEP(P_STEP[g])
    ) u_dut (
      .CLK (clk),
      .RST (rst),
      .LED0(led_o[g][0]),
      .LED1(led_o[g][1]),
      .LED2(led_o[g][2]),
      .LED3(led_o[g][3]),
      .LED4(led_o[g][4]),
      .LED5(led_o[g][5]),
      .LED6(led_o[g][6]),
      .LED7(led_o[g][7])
    );
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected LEDs at the n-th edge after release (n = 0 is the first edge):
  // duty ramps by one per "step" cycles up to the saturated target, and a LED
  // is lit while the position within the PWM period is below that duty.
  function automatic logic [7:0] model(input int g, input int n);
    int full, d, eff;
    logic [7:0] pat;
    full = 1 << P_BITS[g];
    d    = (P_DUTY[g] > full) ? full : P_DUTY[g];
    eff  = (P_STEP[g] > 0) ? ((n / P_STEP[g] < d) ? n / P_STEP[g] : d) : d;
    pat  = 8'(P_PAT[g]);
    return ((n % full) < eff) ? pat : 8'h00;
  endfunction

  task automatic step(input bit r);
    logic [7:0] exp;
    @(negedge clk);
    rst = r;
    @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) begin
      exp = r ? 8'h00 : model(g, n_since);
      chk($sformatf("cfg%0d_cyc%0d%s", g, cyc, r ? "_rst" : ""), led_o[g], exp);
    end
    if (r) n_since = 0;
    else   n_since++;
    cyc++;
  endtask

  initial begin
    // Initial reset held for three cycles, then a long clean run.
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 40; i++) step(1'b0);
    // Single-cycle reset in the middle of a PWM period.
    for (int i = 0; i < 2; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 30; i++) step(1'b0);
    // Random reset pulses of 1..3 cycles amid free running.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        int len;
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++) step(1'b1);
      end else begin
        step(1'b0);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
